mdu: RTL and testbench



---
 rtl/mdu_if.sv | 12 +
 rtl/mdu.sv | 132 +++++++++++++
 tb/tb_mdu.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Handshake/operand bundle between the E-stage datapath and the multiply/divide unit.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] Result;

  modport master (output A, B, MDUOp, Start, input Busy, Result);
  modport slave  (input A, B, MDUOp, Start, output Busy, Result);
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit: fixed-latency mult/div into HI/LO, plus mthi/mtlo/mfhi/mflo.
// The 64-bit result is computed when Start is accepted and held pending until the countdown ends.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r;
  logic            busy_r;
  logic [CW-1:0]   cnt_r;
  logic [31:0]     hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic            div0_r;

  logic            is_mul_s, is_div_s, start_ok_s, b_zero_s;
  logic [63:0]     smul_s, umul_s;
  logic [31:0]     b_safe_s, abs_a_s, abs_b_s, uq_s, ur_s, sq_s, sr_s, dq_s, dr_s;
  logic [63:0]     res_s;
  logic [31:0]     result_s;

  assign is_mul_s   = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
  assign is_div_s   = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
  assign start_ok_s = bus.Start && (is_mul_s || is_div_s) && !busy_r;
  assign b_zero_s   = (bus.B == 32'd0);

  // Operand datapath: products, and signed division done on magnitudes so the
  // 0x80000000 / -1 case falls out naturally as 0x80000000 remainder 0.
  always_comb begin
    smul_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    umul_s   = {32'd0, bus.A} * {32'd0, bus.B};
    b_safe_s = b_zero_s ? 32'd1 : bus.B;
    abs_a_s  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    abs_b_s  = b_safe_s[31] ? (32'd0 - b_safe_s) : b_safe_s;
    sq_s     = abs_a_s / abs_b_s;
    sr_s     = abs_a_s % abs_b_s;
    uq_s     = bus.A / b_safe_s;
    ur_s     = bus.A % b_safe_s;
    dq_s     = (bus.A[31] ^ b_safe_s[31]) ? (32'd0 - sq_s) : sq_s;
    dr_s     = bus.A[31] ? (32'd0 - sr_s) : sr_s;
    case (bus.MDUOp)
      OP_MULT:  res_s = smul_s;
      OP_MULTU: res_s = umul_s;
      OP_DIV:   res_s = {dr_s, dq_s};
      OP_DIVU:  res_s = {ur_s, uq_s};
      default:  res_s = 64'd0;
    endcase
  end

  // Control FSM, countdown, and HI/LO architectural state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      cnt_r     <= '0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      div0_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            pend_hi_r <= res_s[63:32];
            pend_lo_r <= res_s[31:0];
            cnt_r     <= is_mul_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            div0_r    <= is_div_s && b_zero_s;
            state_r   <= RUN;
            busy_r    <= 1'b1;
          end else if (bus.MDUOp == OP_MTHI) begin
            hi_r <= bus.A;
          end else if (bus.MDUOp == OP_MTLO) begin
            lo_r <= bus.A;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_r <= CW'(1)) begin
            // Divide by zero burns the full latency but leaves HI/LO untouched.
            if (!div0_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
            cnt_r   <= '0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Read port for mfhi/mflo; other ops drive zero.
  always_comb begin
    case (bus.MDUOp)
      OP_MFHI: result_s = hi_r;
      OP_MFLO: result_s = lo_r;
      default: result_s = 32'd0;
    endcase
  end

  assign bus.Busy   = busy_r;
  assign bus.Result = result_s;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: latency, HI/LO results, divide corner cases, ignored ops, async reset.
module tb_mdu;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  mdu_if bus ();
  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    bus.MDUOp = 4'd7;
    #1 check({tag, " hi"}, bus.Result, hi);
    bus.MDUOp = 4'd8;
    #1 check({tag, " lo"}, bus.Result, lo);
    bus.MDUOp = 4'd0;
    #1;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDUOp = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0; bus.MDUOp = 4'd0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    start_op(op, a, b);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {31'd0, bus.Busy}, 32'd1);
      step();
    end
    check({tag, " busy drop"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.A = 32'd0; bus.B = 32'd0; bus.MDUOp = 4'd0; bus.Start = 1'b0;
    step(); step();
    check("reset busy", {31'd0, bus.Busy}, 32'd0);
    check("reset result none", bus.Result, 32'd0);
    read_hilo("reset", 32'd0, 32'd0);
    reset = 1'b1;
    step();

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    read_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 10);
    read_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFC);

    bus.MDUOp = 4'd5; bus.A = 32'h1234_5678;
    step();
    bus.MDUOp = 4'd0;
    read_hilo("mthi", 32'h1234_5678, 32'h7FFF_FFFC);

    run_op("div0", 4'd3, 32'd55, 32'd0, 10);
    read_hilo("div0", 32'h1234_5678, 32'h7FFF_FFFC);

    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    read_hilo("divovf", 32'h0000_0000, 32'h8000_0000);

    // Start DIV and MTLO during a MULT must both be dropped.
    start_op(4'd1, 32'd5, 32'd7);
    check("ign c1", {31'd0, bus.Busy}, 32'd1);
    step();
    check("ign c2", {31'd0, bus.Busy}, 32'd1);
    bus.MDUOp = 4'd3; bus.A = 32'd100; bus.B = 32'd3; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check("ign c3", {31'd0, bus.Busy}, 32'd1);
    bus.MDUOp = 4'd6; bus.A = 32'h0000_AAAA;
    step();
    bus.MDUOp = 4'd0;
    check("ign c4", {31'd0, bus.Busy}, 32'd1);
    step();
    check("ign c5", {31'd0, bus.Busy}, 32'd1);
    step();
    check("ign drop", {31'd0, bus.Busy}, 32'd0);
    read_hilo("ign", 32'd0, 32'd35);
    step();
    check("ign no restart", {31'd0, bus.Busy}, 32'd0);

    // Reset during the third cycle of a DIV.
    start_op(4'd3, 32'd100, 32'd3);
    step(); step();
    check("rst pre busy", {31'd0, bus.Busy}, 32'd1);
    #2 reset = 1'b0;
    #1 check("rst busy", {31'd0, bus.Busy}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("rst idle", {31'd0, bus.Busy}, 32'd0);
    read_hilo("rst idle", 32'd0, 32'd0);

    run_op("mult2", 4'd1, 32'h0001_0000, 32'h0001_0000, 5);
    read_hilo("mult2", 32'h0000_0001, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
